// File: rtl/mem_operand_sequencer.sv
// mem_operand_sequencer
// Walks operand-memory addresses 0..Count-1, captures the multiplicand
// (bank 1) and multiplier (bank 2) from the combinational read ports, and
// hands each pair to the Booth multiplier over a valid/ready handshake.
// Addr is driven only while Busy; the loader owns the bus otherwise.
//
// Optional build macro: SEQ_ZERO_SKIP_EN
//   When defined, pairs with a zero operand are dropped in FETCH without
//   being presented, and the Skip_Cnt output counts them.
//
// Handshake: a pair transfers at a posedge where Op_Valid=1 and Op_Ready=1.
// While Op_Valid=1 and Op_Ready=0, Op_A, Op_B and Addr hold steady.
// Op_Ready is ignored while Op_Valid=0. After a transfer only Op_Valid drops;
// Op_A/Op_B keep the last pair.
module mem_operand_sequencer #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Start,
  input  logic [ADDR_WIDTH:0]   Count,
  output logic [ADDR_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] Data1_I,
  input  logic [DATA_WIDTH-1:0] Data2_I,
  output logic [DATA_WIDTH-1:0] Op_A,
  output logic [DATA_WIDTH-1:0] Op_B,
  output logic                  Op_Valid,
  input  logic                  Op_Ready,
  output logic                  Busy,
  output logic                  Done
`ifdef SEQ_ZERO_SKIP_EN
  ,
  output logic [ADDR_WIDTH:0]   Skip_Cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  // Largest legal pair count: the full memory depth.
  localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_CNT   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t              state;
  logic [ADDR_WIDTH:0] remaining;
  logic [ADDR_WIDTH:0] count_clamped;
  logic                last_pair;

  // Clamp oversize requests to the memory depth and flag the final pair.
  always_comb begin
    count_clamped = (Count > MAX_COUNT) ? MAX_COUNT : Count;
    last_pair     = (remaining == ONE_CNT);
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      Addr      <= '0;
      Op_A      <= '0;
      Op_B      <= '0;
      Op_Valid  <= 1'b0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      remaining <= '0;
`ifdef SEQ_ZERO_SKIP_EN
      Skip_Cnt  <= '0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          Addr <= '0;
          if (Start) begin
            remaining <= count_clamped;
            Busy      <= 1'b1;
`ifdef SEQ_ZERO_SKIP_EN
            Skip_Cnt  <= '0;
`endif
            if (Count == '0) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
`ifdef SEQ_ZERO_SKIP_EN
          if ((Data1_I == '0) || (Data2_I == '0)) begin
            // Zero operand: drop the pair without presenting it.
            Skip_Cnt  <= Skip_Cnt + ONE_CNT;
            remaining <= remaining - ONE_CNT;
            if (last_pair) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              Addr <= Addr + ADDR_WIDTH'(1);
            end
          end else begin
            Op_A     <= Data1_I;
            Op_B     <= Data2_I;
            Op_Valid <= 1'b1;
            state    <= S_PRESENT;
          end
`else
          Op_A     <= Data1_I;
          Op_B     <= Data2_I;
          Op_Valid <= 1'b1;
          state    <= S_PRESENT;
`endif
        end

        S_PRESENT: begin
          if (Op_Ready) begin
            Op_Valid  <= 1'b0;
            remaining <= remaining - ONE_CNT;
            if (last_pair) begin
              state <= S_DONE;
              Done  <= 1'b1;
            end else begin
              Addr  <= Addr + ADDR_WIDTH'(1);
              state <= S_FETCH;
            end
          end
        end

        S_DONE: begin
          // Start is deliberately not sampled here.
          state <= S_IDLE;
          Busy  <= 1'b0;
          Addr  <= '0;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_operand_sequencer.sv
// Bench for mem_operand_sequencer: directed sequences against a small
// operand memory model; expected pairs and Done cycles are queued by the
// stimulus and checked by an independent negedge monitor.
module tb_mem_operand_sequencer;

  localparam int DW = 9;
  localparam int AW = 4;
  localparam int EW = 8 + AW + 2 * DW;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          Start;
  logic [AW:0]   Count;
  logic [AW-1:0] Addr;
  logic [DW-1:0] Data1_I;
  logic [DW-1:0] Data2_I;
  logic [DW-1:0] Op_A;
  logic [DW-1:0] Op_B;
  logic          Op_Valid;
  logic          Op_Ready;
  logic          Busy;
  logic          Done;
`ifdef SEQ_ZERO_SKIP_EN
  logic [AW:0]   Skip_Cnt;
`endif

  logic [DW-1:0] mem_a [16];
  logic [DW-1:0] mem_b [16];

  assign Data1_I = mem_a[Addr];
  assign Data2_I = mem_b[Addr];

  mem_operand_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .Start    (Start),
    .Count    (Count),
    .Addr     (Addr),
    .Data1_I  (Data1_I),
    .Data2_I  (Data2_I),
    .Op_A     (Op_A),
    .Op_B     (Op_B),
    .Op_Valid (Op_Valid),
    .Op_Ready (Op_Ready),
    .Busy     (Busy),
    .Done     (Done)
`ifdef SEQ_ZERO_SKIP_EN
    ,
    .Skip_Cnt (Skip_Cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;

  int edge_cnt   = 0;
  int start_edge = 0;
  always @(posedge Clk) edge_cnt <= edge_cnt + 1;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];   // {cycle[7:0], addr, op_a, op_b}
  logic [7:0]    done_q[$];  // expected Done cycle
  int checks   = 0;
  int failures = 0;
  int hs_cnt   = 0;
  int done_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    logic [EW-1:0] e;
    logic [7:0]    rel;
    if (Rst !== 1'b1) begin
      rel = 8'(edge_cnt - start_edge + 1);
      if (Op_Valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pair addr=%0d a=%0d b=%0d cycle=%0d", Addr, Op_A, Op_B, rel);
        end else begin
          e = exp_q[0];
          if ({Addr, Op_A, Op_B} !== e[EW-9:0]) begin
            failures++;
            $display("FAIL pair_value actual addr=%0d a=%0d b=%0d expected addr=%0d a=%0d b=%0d",
                     Addr, Op_A, Op_B, e[EW-9:2*DW], e[2*DW-1:DW], e[DW-1:0]);
          end
          if (Op_Ready === 1'b1) begin
            check("handshake_cycle", int'(rel), int'(e[EW-1:EW-8]));
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end else if (Op_Valid !== 1'b0) begin
        check("op_valid_known", 0, 1);
      end
      if (Done === 1'b1) begin
        done_cnt++;
        checks++;
        if (done_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done cycle=%0d", rel);
        end else begin
          if (rel != done_q[0]) begin
            failures++;
            $display("FAIL done_cycle actual=%0d expected=%0d", rel, done_q[0]);
          end
          void'(done_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic start_seq(input logic [AW:0] c);
    Start = 1'b1;
    Count = c;
    next_cycle();
    Start = 1'b0;
    start_edge = edge_cnt;
  endtask

  task automatic push_pair(input int cyc, input int addr);
    exp_q.push_back({8'(cyc), AW'(addr), mem_a[addr], mem_b[addr]});
  endtask

  task automatic drain(input int limit);
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || Busy) && n < limit) begin
      next_cycle();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || done_q.size() != 0 || Busy) begin
      failures++;
      $display("FAIL drain_timeout pending_pairs=%0d pending_done=%0d busy=%0b",
               exp_q.size(), done_q.size(), Busy);
      exp_q.delete();
      done_q.delete();
    end
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = DW'(i + 1);
      mem_b[i] = DW'(2 * i + 3);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hs0;
    int dn0;
    Rst = 1'b1; Start = 1'b0; Count = '0; Op_Ready = 1'b0;
    fill_mem();
    next_cycle();
    next_cycle();
    @(negedge Clk);
    check("reset_op_valid", int'(Op_Valid), 0);
    check("reset_busy",     int'(Busy), 0);
    check("reset_done",     int'(Done), 0);
    check("reset_addr",     int'(Addr), 0);
    check("reset_op_a",     int'(Op_A), 0);
    check("reset_op_b",     int'(Op_B), 0);
    next_cycle();
    Rst = 1'b0;
    next_cycle();

    // Basic: A={5,7,9}, B={3,-2,4}, ready tied high.
    mem_a[0] = 9'd5; mem_a[1] = 9'd7;     mem_a[2] = 9'd9;
    mem_b[0] = 9'd3; mem_b[1] = 9'h1FE;   mem_b[2] = 9'd4;
    Op_Ready = 1'b1;
    hs0 = hs_cnt; dn0 = done_cnt;
    start_seq(5'd3);
    push_pair(2, 0); push_pair(4, 1); push_pair(6, 2);
    done_q.push_back(8'd7);
    drain(40);
    check("basic_handshakes", hs_cnt - hs0, 3);
    check("basic_done_count", done_cnt - dn0, 1);
    check("retain_op_a", int'(Op_A), 9);
    check("retain_op_b", int'(Op_B), 4);
    check("idle_addr",   int'(Addr), 0);
    next_cycle();

    // Backpressure: Count=2, ready low in cycles 2..6 on pair 0.
    fill_mem();
    Op_Ready = 1'b0;
    hs0 = hs_cnt; dn0 = done_cnt;
    start_seq(5'd2);
    push_pair(7, 0); push_pair(9, 1);
    done_q.push_back(8'd10);
    for (int i = 0; i < 6; i++) next_cycle();
    Op_Ready = 1'b1;
    drain(40);
    check("bp_handshakes", hs_cnt - hs0, 2);
    check("bp_done_count", done_cnt - dn0, 1);
    next_cycle();

    // Count=0: Done in cycle 1, no pair ever presented.
    dn0 = done_cnt;
    start_seq(5'd0);
    done_q.push_back(8'd1);
    drain(10);
    check("zero_done_count", done_cnt - dn0, 1);
    next_cycle();

    // Count=17: clamped to 16 pairs, last address 15.
    hs0 = hs_cnt; dn0 = done_cnt;
    start_seq(5'd17);
    for (int k = 0; k < 16; k++) push_pair(2 + 2 * k, k);
    done_q.push_back(8'd33);
    drain(80);
    check("clamp_handshakes", hs_cnt - hs0, 16);
    check("clamp_done_count", done_cnt - dn0, 1);
    check("clamp_last_op_a", int'(Op_A), 16);
    next_cycle();

    // Start ignored in PRESENT (cycle 2) and in DONE (cycle 7).
    hs0 = hs_cnt; dn0 = done_cnt;
    start_seq(5'd3);
    push_pair(2, 0); push_pair(4, 1); push_pair(6, 2);
    done_q.push_back(8'd7);
    next_cycle();                     // cycle 2: PRESENT
    Start = 1'b1; Count = 5'd1;
    next_cycle();                     // cycle 3
    Start = 1'b0; Count = 5'd5;
    for (int i = 0; i < 4; i++) next_cycle();  // cycle 7: DONE
    Start = 1'b1; Count = 5'd2;
    next_cycle();                     // cycle 8
    Start = 1'b0;
    check("restart_ignored_busy", int'(Busy), 0);
    next_cycle();
    check("restart_ignored_busy2", int'(Busy), 0);
    check("ign_handshakes", hs_cnt - hs0, 3);
    check("ign_done_count", done_cnt - dn0, 1);
    exp_q.delete(); done_q.delete();
    next_cycle();

    // Reset mid-sequence: Count=3, Rst while pair 1 is presented (cycle 4).
    dn0 = done_cnt;
    Op_Ready = 1'b1;
    start_seq(5'd3);
    push_pair(2, 0); push_pair(4, 1);
    next_cycle();                     // cycle 2: pair 0 handshake
    next_cycle();                     // cycle 3: FETCH
    Op_Ready = 1'b0;
    next_cycle();                     // cycle 4: PRESENT pair 1
    Rst = 1'b1;
    next_cycle();                     // cycle 5
    Rst = 1'b0;
    exp_q.delete();
    @(negedge Clk);
    check("rst_mid_op_valid", int'(Op_Valid), 0);
    check("rst_mid_busy",     int'(Busy), 0);
    check("rst_mid_addr",     int'(Addr), 0);
    check("rst_mid_done",     int'(Done), 0);
    for (int i = 0; i < 6; i++) next_cycle();
    check("rst_mid_no_done", done_cnt - dn0, 0);

`ifdef SEQ_ZERO_SKIP_EN
    // Zero skip: A={0,4,6}, B={2,0,1}; only (6,1) presented in cycle 4.
    mem_a[0] = 9'd0; mem_a[1] = 9'd4; mem_a[2] = 9'd6;
    mem_b[0] = 9'd2; mem_b[1] = 9'd0; mem_b[2] = 9'd1;
    Op_Ready = 1'b1;
    hs0 = hs_cnt; dn0 = done_cnt;
    start_seq(5'd3);
    push_pair(4, 2);
    done_q.push_back(8'd5);
    drain(20);
    check("skip_handshakes", hs_cnt - hs0, 1);
    check("skip_done_count", done_cnt - dn0, 1);
    check("skip_cnt", int'(Skip_Cnt), 2);
    next_cycle();
    check("skip_cnt_held", int'(Skip_Cnt), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
